// File: rtl/instr_sequencer.sv
// Run/Done initiator: fetches instruction words (plus the mvi immediate) from a
// synchronous-read program memory and issues them to the processor one at a time.
module instr_sequencer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        InstrCount,
  output logic              Busy,
  output logic              Halt,
  output logic              Err
);

  localparam int unsigned IR_W  = 9;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH_I = 4'd1;
  localparam logic [3:0] S_CAPT_I  = 4'd2;
  localparam logic [3:0] S_FETCH_D = 4'd3;
  localparam logic [3:0] S_CAPT_D  = 4'd4;
  localparam logic [3:0] S_ISSUE   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_GAP     = 4'd7;
  localparam logic [3:0] S_HALT    = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [3:0]        state, state_n;
  logic [IR_W-1:0]   ir, ir_n;
  logic [DATA_W-1:0] imm, imm_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [ADDR_W-1:0] mem_addr_n, pc_n;
  logic [DATA_W-1:0] din_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              run_n, busy_n, halt_n, err_n;
  logic              is_mvi;

  assign is_mvi = (ir[8:6] == OP_MVI);

  // State register plus all registered outputs; reset is synchronous.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      ir         <= '0;
      imm        <= '0;
      timer      <= '0;
      MemAddr    <= '0;
      PC         <= '0;
      DIN        <= '0;
      InstrCount <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Halt       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state      <= state_n;
      ir         <= ir_n;
      imm        <= imm_n;
      timer      <= timer_n;
      MemAddr    <= mem_addr_n;
      PC         <= pc_n;
      DIN        <= din_n;
      InstrCount <= cnt_n;
      Run        <= run_n;
      Busy       <= busy_n;
      Halt       <= halt_n;
      Err        <= err_n;
    end
  end

  // Next-state and next-output decode; DIN is loaded on entry to ISSUE and EXEC.
  always_comb begin
    state_n    = state;
    ir_n       = ir;
    imm_n      = imm;
    timer_n    = timer;
    mem_addr_n = MemAddr;
    pc_n       = PC;
    din_n      = DIN;
    cnt_n      = InstrCount;

    case (state)
      S_IDLE: begin
        if (Start) state_n = S_FETCH_I;
      end
      S_FETCH_I: begin
        mem_addr_n = PC;
        state_n    = S_CAPT_I;
      end
      S_CAPT_I: begin
        ir_n = MemData[IR_W-1:0];
        pc_n = PC + ADDR_W'(1);
        case (MemData[8:6])
          OP_HALT: state_n = S_HALT;
          OP_MVI:  state_n = S_FETCH_D;
          default: begin
            state_n = S_ISSUE;
            din_n   = DATA_W'(MemData[IR_W-1:0]);
          end
        endcase
      end
      S_FETCH_D: begin
        mem_addr_n = PC;
        state_n    = S_CAPT_D;
      end
      S_CAPT_D: begin
        imm_n   = MemData;
        pc_n    = PC + ADDR_W'(1);
        din_n   = DATA_W'(ir);
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        timer_n = '0;
        din_n   = is_mvi ? imm : DATA_W'(ir);
        state_n = S_EXEC;
      end
      S_EXEC: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (Done) begin
          cnt_n   = InstrCount + CNT_W'(1);
          state_n = S_GAP;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_n = S_ERROR;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      S_GAP: begin
        state_n = (Stop || !Start) ? S_IDLE : S_FETCH_I;
      end
      S_HALT:  state_n = S_HALT;
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_IDLE;
    endcase

    run_n  = (state_n == S_ISSUE) || (state_n == S_EXEC);
    busy_n = !((state_n == S_IDLE) || (state_n == S_HALT) || (state_n == S_ERROR));
    halt_n = (state_n == S_HALT);
    err_n  = (state_n == S_ERROR);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs, a Done responder,
// and a monitor that checks every DIN word while Run is high.
module tb_instr_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam logic [15:0] HALT_W = 16'h01C0;

  logic              Clock = 1'b0;
  logic              Resetn, Start, Stop, Done;
  logic [ADDR_W-1:0] MemAddr, PC;
  logic [DATA_W-1:0] MemData, DIN;
  logic              Run, Busy, Halt, Err;
  logic [7:0]        InstrCount;

  logic [DATA_W-1:0] rom [2**ADDR_W];

  // MemAddr is the memory's address register, so read data follows it directly.
  assign MemData = rom[MemAddr];

  instr_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done),
    .PC(PC), .InstrCount(InstrCount), .Busy(Busy), .Halt(Halt), .Err(Err)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] first;
    logic [15:0] exec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  bit   done_en = 1'b0;
  int   done_delay = 2;
  bit   gap_inject = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Done responder: pulse Done done_delay cycles after Run rises; optionally
  // also pulse it in the GAP cycle, where it must be ignored.
  initial begin
    logic drv_prev;
    int   age;
    drv_prev = 1'b0;
    age = 0;
    Done = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (Run === 1'b1 && !drv_prev) age = 0;
      else if (Run === 1'b1) age++;
      Done = (done_en && Run === 1'b1 && age == done_delay) ||
             (gap_inject && Run !== 1'b1 && drv_prev);
      drv_prev = (Run === 1'b1);
    end
  end

  // Monitor: pop one expectation per Run rising edge, check DIN every Run cycle.
  initial begin
    logic        mon_prev;
    logic [15:0] mon_exec;
    exp_t        e;
    mon_prev = 1'b0;
    mon_exec = '0;
    forever begin
      @(negedge Clock);
      if (Run === 1'b1 && !mon_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_run: got Run=1 DIN=0x%0h expected no issue", DIN);
        end else begin
          e = sb.pop_front();
          check("din_issue", 32'(DIN), 32'(e.first));
          mon_exec = e.exec;
        end
      end else if (Run === 1'b1 && mon_prev) begin
        check("din_exec", 32'(DIN), 32'(mon_exec));
      end
      mon_prev = (Run === 1'b1);
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Start = 1'b0;
    Stop = 1'b0;
    done_en = 1'b0;
    gap_inject = 1'b0;
    repeat (2) cyc();
    Resetn = 1'b1;
  endtask

  task automatic load_halts();
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = HALT_W;
  endtask

  task automatic push(input logic [15:0] first, input logic [15:0] exec);
    exp_t e;
    e.first = first;
    e.exec = exec;
    sb.push_back(e);
  endtask

  // Observe Run until Halt or Err: latency of first rise, rise count, low gap
  // lengths between rises and Run-high lengths.
  task automatic watch(input int limit, output int lat, output int rises,
                       output int lo_min, output int lo_max,
                       output int hi_min, output int hi_max);
    int   lo, hi;
    logic prev;
    lo = 0; hi = 0; prev = 1'b0;
    lat = -1; rises = 0; lo_min = 999; lo_max = 0; hi_min = 999; hi_max = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge Clock);
      if (Run === 1'b1 && !prev) begin
        if (rises == 0) lat = n;
        else begin
          if (lo < lo_min) lo_min = lo;
          if (lo > lo_max) lo_max = lo;
        end
        rises++;
      end
      if (Run !== 1'b1 && prev) begin
        if (hi < hi_min) hi_min = hi;
        if (hi > hi_max) hi_max = hi;
      end
      if (Run === 1'b1) begin hi++; lo = 0; end
      else begin lo++; hi = 0; end
      prev = (Run === 1'b1);
      if (Halt === 1'b1 || Err === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL watch_timeout: got no Halt/Err after %0d cycles expected Halt or Err", limit);
  endtask

  // sel 0: Run==1, 1: Run==0, 2: InstrCount==target
  task automatic wait_for(input int sel, input int target, input int limit, input string name);
    for (int n = 0; n < limit; n++) begin
      @(negedge Clock);
      if (sel == 0 && Run === 1'b1) return;
      if (sel == 1 && Run === 1'b0) return;
      if (sel == 2 && InstrCount === 8'(target)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: got timeout after %0d cycles expected condition", name, limit);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, rises, lo_min, lo_max, hi_min, hi_max;

    // Reset state
    load_halts();
    do_reset();
    @(negedge Clock);
    check("rst_run", 32'(Run), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_count", 32'(InstrCount), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halt", 32'(Halt), 32'd0);
    check("rst_err", 32'(Err), 32'd0);

    // mv R1,R2 then halt
    load_halts();
    rom[0] = 16'h000A;
    push(16'h000A, 16'h000A);
    done_en = 1'b1; done_delay = 2;
    cyc();
    Start = 1'b1;
    watch(60, lat, rises, lo_min, lo_max, hi_min, hi_max);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_rises", 32'(rises), 32'd1);
    check("t1_run_len", 32'(hi_max), 32'd3);
    check("t1_halt", 32'(Halt), 32'd1);
    check("t1_pc", 32'(PC), 32'd2);
    check("t1_count", 32'(InstrCount), 32'd1);
    check("t1_busy", 32'(Busy), 32'd0);
    repeat (5) cyc();
    check("t1_run_after", 32'(Run), 32'd0);

    // mvi R0, 0x00A5 then halt
    do_reset();
    load_halts();
    rom[0] = 16'h0040;
    rom[1] = 16'h00A5;
    push(16'h0040, 16'h00A5);
    done_en = 1'b1; done_delay = 2;
    Start = 1'b1;
    watch(60, lat, rises, lo_min, lo_max, hi_min, hi_max);
    check("t2_latency", 32'(lat), 32'd6);
    check("t2_run_len", 32'(hi_max), 32'd3);
    check("t2_halt", 32'(Halt), 32'd1);
    check("t2_pc", 32'(PC), 32'd3);
    check("t2_count", 32'(InstrCount), 32'd1);

    // Three mv back to back, Done after one EXEC cycle, stray Done in each GAP
    do_reset();
    load_halts();
    rom[0] = 16'h0011; rom[1] = 16'h0099; rom[2] = 16'h00D3;
    push(16'h0011, 16'h0011); push(16'h0099, 16'h0099); push(16'h00D3, 16'h00D3);
    done_en = 1'b1; done_delay = 1; gap_inject = 1'b1;
    Start = 1'b1;
    watch(100, lat, rises, lo_min, lo_max, hi_min, hi_max);
    check("t3_rises", 32'(rises), 32'd3);
    check("t3_gap_min", 32'(lo_min), 32'd3);
    check("t3_gap_max", 32'(lo_max), 32'd3);
    check("t3_run_len_min", 32'(hi_min), 32'd2);
    check("t3_run_len_max", 32'(hi_max), 32'd2);
    check("t3_count", 32'(InstrCount), 32'd3);
    check("t3_pc", 32'(PC), 32'd4);

    // Done withheld: timeout after 15 EXEC cycles, then reset clears Err
    do_reset();
    load_halts();
    rom[0] = 16'h000A;
    push(16'h000A, 16'h000A);
    Start = 1'b1;
    watch(80, lat, rises, lo_min, lo_max, hi_min, hi_max);
    check("t4_err", 32'(Err), 32'd1);
    check("t4_run_len", 32'(hi_max), 32'd16);
    check("t4_run", 32'(Run), 32'd0);
    check("t4_busy", 32'(Busy), 32'd0);
    check("t4_count", 32'(InstrCount), 32'd0);
    repeat (5) cyc();
    @(negedge Clock);
    check("t4_err_hold", 32'(Err), 32'd1);
    check("t4_pc_hold", 32'(PC), 32'd1);
    check("t4_run_hold", 32'(Run), 32'd0);
    Resetn = 1'b0;
    Start = 1'b0;
    cyc();
    Resetn = 1'b1;
    @(negedge Clock);
    check("t4_rst_err", 32'(Err), 32'd0);
    check("t4_rst_pc", 32'(PC), 32'd0);
    check("t4_rst_din", 32'(DIN), 32'd0);
    check("t4_rst_busy", 32'(Busy), 32'd0);

    // Done arriving in the 15th EXEC cycle beats the timeout
    do_reset();
    load_halts();
    rom[0] = 16'h000A;
    push(16'h000A, 16'h000A);
    done_en = 1'b1; done_delay = 15;
    Start = 1'b1;
    watch(80, lat, rises, lo_min, lo_max, hi_min, hi_max);
    check("t4b_err", 32'(Err), 32'd0);
    check("t4b_halt", 32'(Halt), 32'd1);
    check("t4b_run_len", 32'(hi_max), 32'd16);
    check("t4b_count", 32'(InstrCount), 32'd1);

    // Run through the whole address space; mvi at the last address reads its
    // immediate from address 0, and Stop during EXEC ends in IDLE after GAP.
    do_reset();
    rom[0] = 16'h1A0B;
    for (int i = 1; i < 31; i++) rom[i] = 16'(i);
    rom[31] = 16'h0048;
    push(16'h000B, 16'h000B);
    for (int i = 1; i < 31; i++) push(16'(i), 16'(i));
    push(16'h0048, 16'h1A0B);
    done_en = 1'b1; done_delay = 1;
    Start = 1'b1;
    wait_for(2, 31, 400, "t5_wait_count");
    wait_for(0, 0, 20, "t5_wait_run");
    Stop = 1'b1;
    wait_for(1, 0, 20, "t5_wait_gap");
    check("t5_busy_gap", 32'(Busy), 32'd1);
    @(negedge Clock);
    check("t5_busy_idle", 32'(Busy), 32'd0);
    check("t5_run", 32'(Run), 32'd0);
    check("t5_pc", 32'(PC), 32'd1);
    check("t5_memaddr", 32'(MemAddr), 32'd0);
    check("t5_count", 32'(InstrCount), 32'd32);
    check("t5_din_hold", 32'(DIN), 32'h1A0B);
    check("t5_halt", 32'(Halt), 32'd0);
    Start = 1'b0;
    Stop = 1'b0;
    repeat (3) cyc();
    @(negedge Clock);
    check("t5_still_idle", 32'(Busy), 32'd0);

    // Reset mid-EXEC, then restart from address 0 with Start held high
    do_reset();
    load_halts();
    rom[0] = 16'h000A; rom[1] = 16'h0011;
    push(16'h000A, 16'h000A);
    Start = 1'b1;
    wait_for(0, 0, 20, "t6_wait_run");
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b0;
    cyc();
    Resetn = 1'b1;
    done_en = 1'b1; done_delay = 2;
    push(16'h000A, 16'h000A);
    push(16'h0011, 16'h0011);
    @(negedge Clock);
    check("t6_rst_run", 32'(Run), 32'd0);
    check("t6_rst_pc", 32'(PC), 32'd0);
    check("t6_rst_count", 32'(InstrCount), 32'd0);
    watch(100, lat, rises, lo_min, lo_max, hi_min, hi_max);
    check("t6_rises", 32'(rises), 32'd2);
    check("t6_count", 32'(InstrCount), 32'd2);
    check("t6_pc", 32'(PC), 32'd3);
    check("t6_halt", 32'(Halt), 32'd1);

    repeat (3) cyc();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
